// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: opcode-driven immediate decoder feeding a DEPTH-entry valid/ready FIFO.
// Optional ZICSR_IMM_EN macro enables the Z-type (CSR zimm) decode.
module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              ins,
   input  logic                     flush,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [XLEN-1:0]          imm,
   output logic [2:0]               imm_type,
   output logic                     illegal,
   output logic [$clog2(DEPTH):0]   count,
   output logic [15:0]              ill_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [XLEN+3:0] mem [DEPTH];
   logic [AW-1:0]   wptr, rptr;
   logic [31:0]     d32;
   logic [XLEN-1:0] dimm;
   logic [2:0]      dtyp;
   logic            dill;
   logic [6:0]      op;
   logic [2:0]      f3;
   logic [5:0]      shamt;
   logic            push, pop;
   assign op    = ins[6:0];
   assign f3    = ins[14:12];
   assign shamt = (XLEN == 64) ? ins[25:20] : {1'b0, ins[24:20]};
   always_comb begin
      d32  = '0;
      dtyp = 3'd7;
      dill = 1'b0;
      case (op)
         7'b0110111, 7'b0010111: begin d32 = {ins[31:12], 12'b0}; dtyp = 3'd4; end
         7'b1101111: begin d32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; dtyp = 3'd5; end
         7'b1100111, 7'b0000011, 7'b0010011, 7'b1110011: begin d32 = {{20{ins[31]}}, ins[31:20]}; dtyp = 3'd1; end
         7'b0100011: begin d32 = {{20{ins[31]}}, ins[31:25], ins[11:7]}; dtyp = 3'd2; end
         7'b1100011: begin d32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; dtyp = 3'd3; end
         7'b0110011: dtyp = 3'd0;
         default: dill = 1'b1;
      endcase
      // shift immediates carry only the shamt field, never the funct7 bits
      dimm = (op == 7'b0010011 && f3[1:0] == 2'b01) ? XLEN'(shamt) : XLEN'($signed(d32));
`ifdef ZICSR_IMM_EN
      if (op == 7'b1110011 && f3[2]) begin
         dimm = XLEN'(ins[19:15]);
         dtyp = 3'd6;
      end
`endif
   end
   assign in_ready  = count < CW'(DEPTH);
   assign out_valid = count != '0;
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready & ~flush;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr    <= '0;
         rptr    <= '0;
         count   <= '0;
         ill_cnt <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         wptr  <= wptr + AW'(push);
         rptr  <= rptr + AW'(pop);
         count <= count + CW'(push) - CW'(pop);
         if (push && dill && ill_cnt != 16'hFFFF) ill_cnt <= ill_cnt + 16'd1;
      end
   end
   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= {dimm, dtyp, dill};
   end
   assign {imm, imm_type, illegal} = out_valid ? mem[rptr] : '0;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: table vectors, FIFO corner sequences and a random run against a queue model,
// with a 32-bit and a 64-bit instance driven in lockstep.
module tb_imm_gen_pipe;
   logic        clk = 0, rst_n = 0, in_valid = 0, flush = 0, out_ready = 0;
   logic [31:0] ins = 0;
   logic        a_ir, a_ov, a_ill, b_ir, b_ov, b_ill;
   logic [31:0] a_imm;
   logic [63:0] b_imm;
   logic [2:0]  a_t, b_t;
   logic [1:0]  a_cnt, b_cnt;
   logic [15:0] a_ic, b_ic;
   int          n_cmp = 0, n_bad = 0;
   logic [31:0] q [$];
   int          mic = 0;

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .DEPTH(2)) u32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_ir), .ins(ins), .flush(flush),
      .out_valid(a_ov), .out_ready(out_ready), .imm(a_imm), .imm_type(a_t), .illegal(a_ill),
      .count(a_cnt), .ill_cnt(a_ic));
   imm_gen_pipe #(.XLEN(64), .DEPTH(2)) u64 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_ir), .ins(ins), .flush(flush),
      .out_valid(b_ov), .out_ready(out_ready), .imm(b_imm), .imm_type(b_t), .illegal(b_ill),
      .count(b_cnt), .ill_cnt(b_ic));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference decode straight from the opcode table, result truncated to xl bits.
   function automatic logic [63:0] ref_imm(input logic [31:0] w, input int xl, output logic [2:0] t);
      logic [63:0] v;
      logic [2:0]  f3;
      f3 = w[14:12];
      v = 0;
      t = 7;
      case (w[6:0])
         7'h37, 7'h17: begin v = 64'($signed({w[31:12], 12'h000})); t = 4; end
         7'h6F: begin v = 64'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0})); t = 5; end
         7'h67, 7'h03, 7'h13, 7'h73: begin
            v = 64'($signed(w[31:20]));
            t = 1;
            if (w[6:0] == 7'h13 && (f3 == 1 || f3 == 5)) v = (xl == 64) ? 64'(w[25:20]) : 64'(w[24:20]);
`ifdef ZICSR_IMM_EN
            if (w[6:0] == 7'h73 && f3 >= 4) begin v = 64'(w[19:15]); t = 6; end
`endif
         end
         7'h23: begin v = 64'($signed({w[31:25], w[11:7]})); t = 2; end
         7'h63: begin v = 64'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0})); t = 3; end
         7'h33: t = 0;
         default: ;
      endcase
      return (xl == 32) ? {32'h0, v[31:0]} : v;
   endfunction

   task automatic step();
      bit pu, po;
      logic [2:0] t;
      logic [63:0] dummy;
      pu = in_valid && q.size() < 2 && !flush;
      po = q.size() > 0 && out_ready && !flush;
      @(posedge clk);
      #1;
      if (flush) q.delete();
      else begin
         if (po) void'(q.pop_front());
         if (pu) begin
            q.push_back(ins);
            dummy = ref_imm(ins, 32, t);
            if (t == 7 && mic < 65535) mic++;
         end
      end
   endtask

   task automatic cmp_model();
      logic [2:0] t;
      logic [63:0] e32, e64;
      bit v;
      v = q.size() > 0;
      t = 0;
      e32 = 0;
      e64 = 0;
      if (v) begin
         e32 = ref_imm(q[0], 32, t);
         e64 = ref_imm(q[0], 64, t);
      end
      chk("cnt32", 64'(a_cnt), 64'(q.size()));
      chk("cnt64", 64'(b_cnt), 64'(q.size()));
      chk("ov32", 64'(a_ov), 64'(v));
      chk("ov64", 64'(b_ov), 64'(v));
      chk("ir32", 64'(a_ir), 64'(q.size() < 2));
      chk("ir64", 64'(b_ir), 64'(q.size() < 2));
      chk("imm32", 64'(a_imm), e32);
      chk("imm64", b_imm, e64);
      chk("typ32", 64'(a_t), 64'(t));
      chk("typ64", 64'(b_t), 64'(t));
      chk("ill32", 64'(a_ill), 64'(v && t == 7));
      chk("ill64", 64'(b_ill), 64'(v && t == 7));
      chk("ic32", 64'(a_ic), 64'(mic));
      chk("ic64", 64'(b_ic), 64'(mic));
   endtask

   task automatic do_reset();
      in_valid = 0;
      flush = 0;
      out_ready = 0;
      rst_n = 0;
      q.delete();
      mic = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1;
   endtask

   typedef struct {
      logic [31:0] w;
      logic [31:0] e32;
      logic [63:0] e64;
      logic [2:0]  t;
      logic        ill;
   } vec_t;

   initial begin
      vec_t vt [11];
      logic [6:0] ops [11];
      logic [31:0] r;
      vt[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0};
      vt[1]  = '{32'hFE000EE3, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0};
      vt[2]  = '{32'h12345037, 32'h12345000, 64'h0000000012345000, 3'd4, 1'b0};
      vt[3]  = '{32'h800000B7, 32'h80000000, 64'hFFFFFFFF80000000, 3'd4, 1'b0};
      vt[4]  = '{32'h0000007F, 32'h00000000, 64'h0, 3'd7, 1'b1};
      vt[5]  = '{32'h43F0D093, 32'h0000001F, 64'h000000000000003F, 3'd1, 1'b0};
      vt[6]  = '{32'hFE112E23, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0};
      vt[7]  = '{32'h0080006F, 32'h00000008, 64'h8, 3'd5, 1'b0};
      vt[8]  = '{32'h002081B3, 32'h00000000, 64'h0, 3'd0, 1'b0};
`ifdef ZICSR_IMM_EN
      vt[9]  = '{32'h3400D073, 32'h00000001, 64'h1, 3'd6, 1'b0};
`else
      vt[9]  = '{32'h3400D073, 32'h00000340, 64'h340, 3'd1, 1'b0};
`endif
      vt[10] = '{32'h80012083, 32'hFFFFF800, 64'hFFFFFFFFFFFFF800, 3'd1, 1'b0};
      ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h73, 7'h23, 7'h63, 7'h33, 7'h7F};

      do_reset();
      #1;
      cmp_model();

      // decode table, streaming with a pop every cycle
      out_ready = 1;
      for (int i = 0; i < 11; i++) begin
         in_valid = 1;
         ins = vt[i].w;
         step();
         chk($sformatf("tv%0d_ov", i), 64'(a_ov), 64'd1);
         chk($sformatf("tv%0d_imm32", i), 64'(a_imm), 64'(vt[i].e32));
         chk($sformatf("tv%0d_imm64", i), b_imm, vt[i].e64);
         chk($sformatf("tv%0d_typ", i), 64'(a_t), 64'(vt[i].t));
         chk($sformatf("tv%0d_typ64", i), 64'(b_t), 64'(vt[i].t));
         chk($sformatf("tv%0d_ill", i), 64'(a_ill), 64'(vt[i].ill));
      end
      in_valid = 0;
      step();
      chk("drain_ov", 64'(a_ov), 64'd0);
      chk("drain_imm", 64'(a_imm), 64'd0);
      chk("tbl_ic", 64'(a_ic), 64'd1);

      // fill to full, third word held, then flush with an illegal word presented
      out_ready = 0;
      in_valid = 1;
      ins = 32'h00100093;
      step();
      chk("fill1_cnt", 64'(a_cnt), 64'd1);
      chk("fill1_ir", 64'(a_ir), 64'd1);
      ins = 32'h00200093;
      step();
      chk("fill2_cnt", 64'(a_cnt), 64'd2);
      chk("fill2_ir", 64'(a_ir), 64'd0);
      ins = 32'h00300093;
      step();
      chk("fill3_cnt", 64'(a_cnt), 64'd2);
      chk("fill3_head", 64'(a_imm), 64'd1);
      out_ready = 1;
      in_valid = 0;
      step();
      chk("pop_head", 64'(a_imm), 64'd2);
      chk("pop_cnt", 64'(a_cnt), 64'd1);
      in_valid = 1;
      ins = 32'h0000007F;
      flush = 1;
      step();
      chk("flush_cnt", 64'(a_cnt), 64'd0);
      chk("flush_ov", 64'(a_ov), 64'd0);
      chk("flush_cnt64", 64'(b_cnt), 64'd0);
      chk("flush_ic", 64'(a_ic), 64'd1);
      flush = 0;
      in_valid = 0;

      // illegal counting then asynchronous reset between edges
      do_reset();
      in_valid = 1;
      ins = 32'h0000007F;
      step();
      step();
      in_valid = 0;
      chk("ill_cnt2", 64'(a_ic), 64'd2);
      chk("ill_count", 64'(a_cnt), 64'd2);
      chk("ill_flag", 64'(a_ill), 64'd1);
      chk("ill_typ", 64'(a_t), 64'd7);
      chk("ill_imm", b_imm, 64'd0);
      #3;
      rst_n = 0;
      #1;
      chk("arst_ov", 64'(a_ov), 64'd0);
      chk("arst_ic", 64'(a_ic), 64'd0);
      chk("arst_cnt", 64'(a_cnt), 64'd0);
      chk("arst_ov64", 64'(b_ov), 64'd0);
      q.delete();
      mic = 0;
      @(negedge clk);
      rst_n = 1;

      // random traffic against the queue model
      for (int i = 0; i < 400; i++) begin
         in_valid = ($urandom % 4) != 0;
         out_ready = ($urandom % 3) != 0;
         flush = ($urandom % 16) == 0;
         r = $urandom;
         if (($urandom % 8) != 0) r[6:0] = ops[$urandom % 11];
         ins = r;
         step();
         cmp_model();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
